frame_buffer_reader: RTL and testbench
======================================

FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 Parameter H_RES, default 640, Y-plane width in samples.
REQ-002 Parameter V_RES, default 480, Y-plane height in lines.
REQ-003 Parameter SPW, default 5, 8-bit samples packed per memory word.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse that begins a full-frame read.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse after the last sample is accepted.
REQ-009 rd_req  output  1  memory read request, held until rd_ack.
REQ-010 rd_buf  output  1  frame buffer select: 0 = Y buffer, 1 = chroma buffer.
REQ-011 rd_addr  output  16  word address within the selected buffer.
REQ-012 rd_ack  input  1  request accepted this cycle.
REQ-013 rd_valid  input  1  rd_data valid; one cycle, at least 1 cycle after rd_ack.
REQ-014 rd_data  input  40  packed word; sample k occupies bits [8k+7:8k].
REQ-015 pix_valid  output  1  sample output valid.
REQ-016 pix_ready  input  1  downstream accepts the sample when valid and ready are both high.
REQ-017 pix_data  output  8  sample value.
REQ-018 pix_plane  output  2  plane tag: 00 = Y, 01 = U, 10 = V.
REQ-019 pix_row, pix_col  output  10 each  sample coordinates within the plane.
REQ-020 pix_last  output  1  high with the final V sample of the frame.

Function
REQ-021 Memory layout: Y plane (H_RES x V_RES) in buffer 0 at words 0..61439; U plane (H_RES/2 x V_RES/2) in buffer 1 at words 0..15359; V plane in buffer 1 at words 15360..30719; raster order; word address = sample index / SPW.
REQ-022 FSM states: IDLE, REQ, WAIT, EMIT, DONE.
REQ-023 IDLE -> REQ on start; start is ignored in any other state.
REQ-024 REQ: rd_req = 1 with a stable rd_buf/rd_addr; -> WAIT in the cycle rd_ack is high.
REQ-025 WAIT: capture rd_data into the word register on rd_valid; -> EMIT.
REQ-026 rd_valid outside WAIT is ignored; at most one read is outstanding.
REQ-027 EMIT: present samples 0..SPW-1 in order, one per handshake; hold pix_* stable while pix_ready is low.
REQ-028 EMIT exit: after sample SPW-1 is accepted, -> REQ with the next address, or -> DONE if it was the final V sample.
REQ-029 Column wrap: col wraps from width-1 to 0 and increments row.
REQ-030 Plane wrap: row wraps from height-1 to 0; plane advances Y -> U -> V; rd_buf goes to 1 at the Y -> U transition.
REQ-031 Plane sizes are multiples of SPW, so no word spans two planes or lines.
REQ-032 DONE: done = 1 for one cycle; busy falls in the same cycle; -> IDLE.
REQ-033 Throughput: minimum 2 cycles of request/latency per word plus SPW cycles of emission; no prefetch.

Reset
REQ-034 On reset_n low (any state, including mid-transfer): FSM -> IDLE; rd_req, pix_valid, pix_last, busy and done = 0; counters, rd_addr, rd_buf, pix_plane, pix_row, pix_col and pix_data = 0.
REQ-035 A read outstanding at reset is abandoned; a stray rd_valid after reset is ignored.

Structure
REQ-036 Package cam_pkg holds: the plane enum (Y/U/V), H_RES/V_RES defaults, the U base (0) and V base (15360) word addresses, and the word width (40).
REQ-037 Sub-module fb_word_unpack holds the 40-bit word register and the sample index 0..SPW-1, and flags the last sample.
REQ-038 Row/col/plane counters and the FSM reside in the top module.

Verification
REQ-039 Reset, then start with rd_ack/rd_valid 1 cycle later and pix_ready = 1 -> first request buf = 0, addr = 0; word 0x0504030201 emits 01..05 at (Y, 0, 0..4).
REQ-040 Y sample 639 -> next sample (Y, row 1, col 0); Y (479, 639) -> next rd_buf = 1, rd_addr = 0, plane U (0, 0).
REQ-041 U (239, 319) -> rd_addr = 15360, plane V; V (239, 319) -> pix_last = 1, then done pulses once, busy = 0.
REQ-042 pix_ready low for 7 cycles during sample 2 -> pix_data/row/col held; no sample lost or duplicated.
REQ-043 Start pulsed while busy, plus a spurious rd_valid in REQ -> both ignored; address sequence unchanged.
REQ-044 reset_n low during WAIT, late rd_valid after release -> all outputs 0; state IDLE until the next start.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame-buffer readers.
// Plane tags, default Y-plane geometry and the packed memory word layout.
package cam_pkg;

    typedef enum logic [1:0] {
        PLANE_Y = 2'b00,
        PLANE_U = 2'b01,
        PLANE_V = 2'b10
    } plane_t;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int WORD_W    = 40;
    localparam int SAMPLE_W  = 8;

    // Number of words in one 4:2:0 chroma plane for the given geometry.
    function automatic logic [15:0] chroma_words(input int h_res, input int v_res, input int spw);
        return 16'(((h_res / 2) * (v_res / 2)) / spw);
    endfunction

    localparam logic [15:0] U_BASE = 16'd0;
    localparam logic [15:0] V_BASE = U_BASE + chroma_words(H_RES_DEF, V_RES_DEF, 5);

endpackage

// File: rtl/fb_word_unpack.sv
// Holds one fetched memory word and steps through its packed samples,
// flagging the final sample so the reader knows when to fetch again.
module fb_word_unpack
    import cam_pkg::*;
#(
    parameter int SPW = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                advance,
    input  logic [WORD_W-1:0]   word,
    output logic [SAMPLE_W-1:0] sample,
    output logic                last
);

    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);

    logic [WORD_W-1:0]   word_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [SAMPLE_W-1:0] lanes [SPW];

    generate
        for (genvar gi = 0; gi < SPW; gi++) begin : g_lane
            assign lanes[gi] = word_reg[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    assign sample = lanes[idx_reg];
    assign last   = (idx_reg == IDX_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_reg <= '0;
            idx_reg  <= '0;
        end else if (load) begin
            word_reg <= word;
            idx_reg  <= '0;
        end else if (advance) begin
            idx_reg  <= last ? '0 : idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/frame_buffer_reader.sv
// Reads one full YUV 4:2:0 frame from packed frame-buffer memory, one word at a
// time, and streams the samples out tagged with plane, row and column.
module frame_buffer_reader
    import cam_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int SPW   = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_req,
    output logic                rd_buf,
    output logic [15:0]         rd_addr,
    input  logic                rd_ack,
    input  logic                rd_valid,
    input  logic [WORD_W-1:0]   rd_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [SAMPLE_W-1:0] pix_data,
    output logic [1:0]          pix_plane,
    output logic [9:0]          pix_row,
    output logic [9:0]          pix_col,
    output logic                pix_last
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [9:0] Y_COL_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_ROW_LAST = 10'(V_RES - 1);
    localparam logic [9:0] C_COL_LAST = 10'(H_RES / 2 - 1);
    localparam logic [9:0] C_ROW_LAST = 10'(V_RES / 2 - 1);

    // The V plane sits directly after the U plane in the chroma buffer.
    localparam logic [15:0] V_BASE_ADDR =
        (H_RES == H_RES_DEF && V_RES == V_RES_DEF && SPW == 5) ? V_BASE
                                                               : U_BASE + chroma_words(H_RES, V_RES, SPW);

    logic [2:0]  state_reg;
    plane_t      plane_reg;
    logic [9:0]  row_reg;
    logic [9:0]  col_reg;
    logic [15:0] addr_reg;
    logic        buf_reg;

    logic [9:0]  col_last;
    logic [9:0]  row_last;
    logic        at_col_end;
    logic        at_row_end;
    logic        final_sample;
    logic        handshake;
    logic        word_load;
    logic        word_last;

    assign handshake = (state_reg == ST_EMIT) && pix_ready;
    assign word_load = (state_reg == ST_WAIT) && rd_valid;

    fb_word_unpack #(
        .SPW(SPW)
    ) u_unpack (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (word_load),
        .advance(handshake),
        .word   (rd_data),
        .sample (pix_data),
        .last   (word_last)
    );

    always_comb begin
        col_last     = (plane_reg == PLANE_Y) ? Y_COL_LAST : C_COL_LAST;
        row_last     = (plane_reg == PLANE_Y) ? Y_ROW_LAST : C_ROW_LAST;
        at_col_end   = (col_reg == col_last);
        at_row_end   = (row_reg == row_last);
        final_sample = (plane_reg == PLANE_V) && at_col_end && at_row_end;
    end

    assign busy      = (state_reg == ST_REQ) || (state_reg == ST_WAIT) || (state_reg == ST_EMIT);
    assign done      = (state_reg == ST_DONE);
    assign rd_req    = (state_reg == ST_REQ);
    assign rd_buf    = buf_reg;
    assign rd_addr   = addr_reg;
    assign pix_valid = (state_reg == ST_EMIT);
    assign pix_plane = plane_reg;
    assign pix_row   = row_reg;
    assign pix_col   = col_reg;
    assign pix_last  = (state_reg == ST_EMIT) && final_sample && word_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            plane_reg <= PLANE_Y;
            row_reg   <= '0;
            col_reg   <= '0;
            addr_reg  <= '0;
            buf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_REQ;
                        plane_reg <= PLANE_Y;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        addr_reg  <= '0;
                        buf_reg   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (rd_ack) state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_valid) state_reg <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (handshake) begin
                        if (at_col_end) begin
                            col_reg <= '0;
                            if (at_row_end) begin
                                row_reg   <= '0;
                                plane_reg <= (plane_reg == PLANE_Y) ? PLANE_U : PLANE_V;
                            end else begin
                                row_reg <= row_reg + 10'd1;
                            end
                        end else begin
                            col_reg <= col_reg + 10'd1;
                        end
                        // Plane sizes are word multiples, so a plane wrap always ends a word.
                        if (word_last) begin
                            if (final_sample) begin
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg <= ST_REQ;
                                if (at_col_end && at_row_end) begin
                                    buf_reg  <= 1'b1;
                                    addr_reg <= (plane_reg == PLANE_Y) ? U_BASE : V_BASE_ADDR;
                                end else begin
                                    addr_reg <= addr_reg + 16'd1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    plane_reg <= PLANE_Y;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    addr_reg  <= '0;
                    buf_reg   <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader on a reduced 20x4 frame: expected
// samples and read addresses are queued at start, a monitor and a memory model check them.
module tb_frame_buffer_reader;

    localparam int H     = 20;
    localparam int V     = 4;
    localparam int SPW   = 5;
    localparam int TB_VB = 4;   // (10 * 2) / 5 words in the U plane

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        rd_req;
    logic        rd_buf;
    logic [15:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [39:0] rd_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic [1:0]  pix_plane;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic        pix_last;

    logic        mem_en;
    logic        mem_ack;
    logic        mem_valid;
    logic [39:0] mem_data;
    logic        man_ack;
    logic        man_valid;
    logic [39:0] man_data;

    int total;
    int bad;
    int done_cnt;

    logic [30:0] sb_q [$];
    logic [16:0] aq [$];

    assign rd_ack   = mem_ack | man_ack;
    assign rd_valid = mem_valid | man_valid;
    assign rd_data  = mem_valid ? mem_data : man_data;

    frame_buffer_reader #(
        .H_RES(H),
        .V_RES(V),
        .SPW  (SPW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_buf   (rd_buf),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data (pix_data),
        .pix_plane(pix_plane),
        .pix_row  (pix_row),
        .pix_col  (pix_col),
        .pix_last (pix_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic b, input int addr, input int k);
        return 8'((b ? 128 : 0) + addr * 5 + k + 1);
    endfunction

    function automatic logic [39:0] mem_word(input logic b, input int addr);
        logic [39:0] w;
        w = '0;
        for (int k = 0; k < SPW; k++) w[k*8 +: 8] = mem_byte(b, addr, k);
        return w;
    endfunction

    // Queue the expected samples of the first sample_words words and the
    // expected read addresses of the first addr_words words of a frame.
    task automatic push_frame(input int sample_words, input int addr_words);
        int wcount;
        int w;
        int h;
        int a;
        int k;
        logic b;
        wcount = 0;
        for (int p = 0; p < 3; p++) begin
            w = (p == 0) ? H : H / 2;
            h = (p == 0) ? V : V / 2;
            b = (p != 0);
            for (int i = 0; i < w * h; i++) begin
                a = ((p == 2) ? TB_VB : 0) + i / SPW;
                k = i % SPW;
                if (k == 0 && wcount < addr_words) aq.push_back({b, 16'(a)});
                if (wcount < sample_words)
                    sb_q.push_back({2'(p), 10'(i / w), 10'(i % w), mem_byte(b, a, k),
                                    1'(p == 2 && i == w * h - 1)});
                if (k == SPW - 1) wcount++;
            end
        end
    endtask

    // Sample monitor: pops the scoreboard on every accepted sample.
    always @(negedge clk) begin
        if (reset_n && done) done_cnt++;
        if (reset_n && pix_valid && pix_ready) begin
            if (sb_q.size() == 0)
                chk("sample_unexpected", {pix_plane, pix_row, pix_col, pix_data, pix_last}, 31'h7fffffff);
            else
                chk("sample", {pix_plane, pix_row, pix_col, pix_data, pix_last}, sb_q.pop_front());
        end
    end

    // Memory model: ack one cycle after a request, data one cycle after the ack.
    always begin
        logic        cap_buf;
        logic [15:0] cap_addr;
        @(posedge clk);
        #1;
        if (reset_n && rd_req && mem_en) begin
            cap_buf  = rd_buf;
            cap_addr = rd_addr;
            $display("rd buf=%0d addr=%0d", cap_buf, cap_addr);
            chk("rd_addr", {rd_buf, rd_addr}, (aq.size() != 0) ? aq.pop_front() : 17'h1ffff);
            @(posedge clk);
            #1;
            chk("req_hold", {rd_req, rd_buf, rd_addr}, {1'b1, cap_buf, cap_addr});
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_valid = 1'b1;
            mem_data  = mem_word(cap_buf, int'(cap_addr));
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_frame_done(input string nm, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) chk({nm, "_timeout"}, 64'(n), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_once"}, 64'(done_cnt - base), 64'd1);
        chk({nm, "_busy_low"}, {63'd0, busy}, 64'd0);
        chk({nm, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({nm, "_aq_empty"}, 64'(aq.size()), 64'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {rd_req, pix_valid, pix_last, busy, done, rd_buf, rd_addr,
                 pix_plane, pix_row, pix_col, pix_data}, 64'd0);
    endtask

    initial begin
        int base;
        int n;
        logic [30:0] held;
        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b1;
        mem_en    = 1'b1;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        man_ack   = 1'b0;
        man_valid = 1'b0;
        man_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: plain full-frame read with continuous ready.
        push_frame(999, 999);
        base = done_cnt;
        pulse_start();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_frame_done("f1", base);

        // Frame 2: start and rd_valid while in REQ, then backpressure on sample 2.
        push_frame(999, 999);
        base = done_cnt;
        pulse_start();
        man_valid = 1'b1;
        man_data  = 40'hdeadbeef99;
        start     = 1'b1;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        start     = 1'b0;
        n = 0;
        while (!(pix_valid && pix_plane == 2'd0 && pix_row == 10'd0 && pix_col == 10'd2) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_found", 64'(n < 200), 64'd1);
        pix_ready = 1'b0;
        held = {pix_plane, pix_row, pix_col, pix_data, pix_valid};
        chk("hold_sample", {56'd0, pix_data}, 64'h03);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", {pix_plane, pix_row, pix_col, pix_data, pix_valid}, held);
        end
        pix_ready = 1'b1;
        wait_frame_done("f2", base);

        // Frame 3: reset while waiting for word 3, then a stray rd_valid.
        push_frame(3, 4);
        pulse_start();
        n = 0;
        while (!(busy && !rd_req && !pix_valid && rd_addr == 16'd3) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_found", 64'(n < 300), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("reset_in_wait");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset_held");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        man_valid = 1'b1;
        man_data  = 40'h1122334455;
        @(posedge clk);
        #1;
        man_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk("idle_after_reset", {rd_req, pix_valid, busy, done}, 64'd0);
        end
        chk("f3_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("f3_aq_empty", 64'(aq.size()), 64'd0);

        // Frame 4: a clean frame after the aborted one.
        push_frame(999, 999);
        base = done_cnt;
        pulse_start();
        wait_frame_done("f4", base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
